// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared definitions for the traffic phase controller: phase
//               enumeration, lamp encodings ({red,yellow,green}) and default
//               phase durations in signal_change ticks.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        RED_A     = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        RED_B     = 3'd5,
        PED_WALK  = 3'd6
    } phase_e;

    // Lamp encodings, bit order {red, yellow, green}
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    // Default phase durations (ticks) and counter width
    localparam int DEF_GREEN_TICKS  = 4;
    localparam int DEF_YELLOW_TICKS = 1;
    localparam int DEF_ALLRED_TICKS = 1;
    localparam int DEF_WALK_TICKS   = 3;
    localparam int DEF_CNT_W        = 4;

endpackage
`default_nettype wire

// File: rtl/traffic_phase_fsm.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_fsm
// Description : Two-direction traffic light phase sequencer with an optional
//               pedestrian walk phase inserted after the second all-red.
//               Phases advance on signal_change ticks; lamps are Moore
//               decoded from the registered phase.
// Ports       : clk           - clock, rising edge
//               rst           - synchronous active-high reset (to RED_B)
//               signal_change - phase timer tick, one tick per high cycle
//               ped_req       - pedestrian request, sampled every cycle
//               ns_light      - north-south lamps {red,yellow,green}
//               ew_light      - east-west lamps {red,yellow,green}
//               walk          - pedestrian walk lamp
//               ped_pending   - latched pedestrian request awaiting service
//               phase         - current phase encoding (phase_e)
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_fsm
    import traffic_pkg::*;
#(
    parameter int GREEN_TICKS  = DEF_GREEN_TICKS,
    parameter int YELLOW_TICKS = DEF_YELLOW_TICKS,
    parameter int ALLRED_TICKS = DEF_ALLRED_TICKS,
    parameter int WALK_TICKS   = DEF_WALK_TICKS,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       signal_change,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    // Terminal count per phase: a duration of D ticks ends when the counter
    // reads D-1 on a tick. Durations up to 2**CNT_W therefore fit the counter.
    localparam logic [CNT_W-1:0] c_green_last  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] c_yellow_last = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] c_allred_last = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] c_walk_last   = CNT_W'(WALK_TICKS - 1);

    phase_e           r_state;
    phase_e           w_next;
    logic [CNT_W-1:0] r_tick_cnt;
    logic [CNT_W-1:0] w_last;
    logic             w_adv;
    logic             r_ped_pending;

    // ------------------------------------------------------------------------
    // Registered state, tick counter and pedestrian latch
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RED_B;
            r_tick_cnt    <= '0;
            r_ped_pending <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_adv) begin
                r_tick_cnt <= '0;
            end else if (signal_change) begin
                r_tick_cnt <= r_tick_cnt + CNT_W'(1);
            end

            // A new request on the entry edge wins over the clear, so it is
            // carried forward to the next RED_B exit.
            if (ped_req) begin
                r_ped_pending <= 1'b1;
            end else if (w_next == PED_WALK && r_state != PED_WALK) begin
                r_ped_pending <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Phase duration, lamp decode and next-state
    // ------------------------------------------------------------------------
    always_comb begin
        w_next   = r_state;
        w_last   = c_allred_last;
        ns_light = RED;
        ew_light = RED;
        walk     = 1'b0;

        case (r_state)
            NS_GREEN: begin
                w_last   = c_green_last;
                ns_light = GREEN;
            end
            NS_YELLOW: begin
                w_last   = c_yellow_last;
                ns_light = YELLOW;
            end
            EW_GREEN: begin
                w_last   = c_green_last;
                ew_light = GREEN;
            end
            EW_YELLOW: begin
                w_last   = c_yellow_last;
                ew_light = YELLOW;
            end
            PED_WALK: begin
                w_last = c_walk_last;
                walk   = 1'b1;
            end
            default: begin
                w_last = c_allred_last;
            end
        endcase

        w_adv = signal_change && (r_tick_cnt == w_last);

        if (w_adv) begin
            case (r_state)
                NS_GREEN:  w_next = NS_YELLOW;
                NS_YELLOW: w_next = RED_A;
                RED_A:     w_next = EW_GREEN;
                EW_GREEN:  w_next = EW_YELLOW;
                EW_YELLOW: w_next = RED_B;
                RED_B:     w_next = r_ped_pending ? PED_WALK : NS_GREEN;
                default:   w_next = NS_GREEN;
            endcase
        end
    end

    assign ped_pending = r_ped_pending;
    assign phase       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_phase_fsm
// Description : Self-checking bench for traffic_phase_fsm with default
//               parameters: a table of per-cycle vectors followed by
//               hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_fsm;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       signal_change = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [2:0] phase;
    logic       walk;
    logic       ped_pending;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    traffic_phase_fsm dut (
        .clk           (clk),
        .rst           (rst),
        .signal_change (signal_change),
        .ped_req       (ped_req),
        .ns_light      (ns_light),
        .ew_light      (ew_light),
        .walk          (walk),
        .ped_pending   (ped_pending),
        .phase         (phase)
    );

    typedef struct {
        logic   sc;
        logic   pr;
        logic   r;
        phase_e ph;
        logic   ped;
    } vec_t;

    vec_t tbl [27];

    // One clock: drive on the falling edge, sample 1ns after the rising edge
    task automatic step(input logic sc, input logic pr, input logic r);
        @(negedge clk);
        signal_change = sc;
        ped_req       = pr;
        rst           = r;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] exp_ns(input phase_e p);
        case (p)
            NS_GREEN:  return 3'b001;
            NS_YELLOW: return 3'b010;
            default:   return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] exp_ew(input phase_e p);
        case (p)
            EW_GREEN:  return 3'b001;
            EW_YELLOW: return 3'b010;
            default:   return 3'b100;
        endcase
    endfunction

    // Phase observed after the k-th consecutive tick starting from RED_B
    function automatic phase_e pat(input int k);
        case ((k - 1) % 12)
            0, 1, 2, 3: return NS_GREEN;
            4:          return NS_YELLOW;
            5:          return RED_A;
            6, 7, 8, 9: return EW_GREEN;
            10:         return EW_YELLOW;
            default:    return RED_B;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string name, input phase_e p, input logic ped);
        logic ok;
        chk({name, ".phase"}, 32'(phase), 32'(p));
        chk({name, ".ns"}, 32'(ns_light), 32'(exp_ns(p)));
        chk({name, ".ew"}, 32'(ew_light), 32'(exp_ew(p)));
        chk({name, ".walk"}, 32'(walk), 32'(p == PED_WALK));
        chk({name, ".ped"}, 32'(ped_pending), 32'(ped));
        ok = $onehot(ns_light) && $onehot(ew_light)
             && !(ns_light != 3'b100 && ew_light != 3'b100)
             && !(walk && (ns_light != 3'b100 || ew_light != 3'b100));
        chk({name, ".legal"}, 32'(ok), 32'd1);
    endtask

    initial begin
        // sc, pr, rst, expected phase, expected ped_pending
        tbl[0]  = '{1'b0, 1'b0, 1'b1, RED_B,     1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, NS_GREEN,  1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, NS_GREEN,  1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, NS_GREEN,  1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, NS_GREEN,  1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, NS_GREEN,  1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, NS_YELLOW, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, RED_A,     1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, EW_GREEN,  1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, EW_GREEN,  1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, EW_GREEN,  1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, EW_GREEN,  1'b1};
        tbl[12] = '{1'b1, 1'b0, 1'b0, EW_GREEN,  1'b1};
        tbl[13] = '{1'b1, 1'b0, 1'b0, EW_YELLOW, 1'b1};
        tbl[14] = '{1'b1, 1'b0, 1'b0, RED_B,     1'b1};
        tbl[15] = '{1'b1, 1'b0, 1'b0, PED_WALK,  1'b0};
        tbl[16] = '{1'b1, 1'b0, 1'b0, PED_WALK,  1'b0};
        tbl[17] = '{1'b1, 1'b0, 1'b0, PED_WALK,  1'b0};
        tbl[18] = '{1'b1, 1'b0, 1'b0, NS_GREEN,  1'b0};
        tbl[19] = '{1'b1, 1'b0, 1'b0, NS_GREEN,  1'b0};
        tbl[20] = '{1'b1, 1'b0, 1'b0, NS_GREEN,  1'b0};
        tbl[21] = '{1'b1, 1'b1, 1'b1, RED_B,     1'b0};
        tbl[22] = '{1'b1, 1'b0, 1'b0, NS_GREEN,  1'b0};
        tbl[23] = '{1'b1, 1'b0, 1'b0, NS_GREEN,  1'b0};
        tbl[24] = '{1'b1, 1'b0, 1'b0, NS_GREEN,  1'b0};
        tbl[25] = '{1'b1, 1'b0, 1'b0, NS_GREEN,  1'b0};
        tbl[26] = '{1'b1, 1'b0, 1'b0, NS_YELLOW, 1'b0};

        for (int i = 0; i < 27; i++) begin
            step(tbl[i].sc, tbl[i].pr, tbl[i].r);
            chk_state($sformatf("vec%0d", i), tbl[i].ph, tbl[i].ped);
        end

        // Ticks every 10 cycles: phase holds between ticks
        step(1'b0, 1'b0, 1'b1);
        chk_state("spaced_rst", RED_B, 1'b0);
        for (int k = 1; k <= 24; k++) begin
            step(1'b1, 1'b0, 1'b0);
            chk_state($sformatf("spaced_t%0d", k), pat(k), 1'b0);
            for (int j = 0; j < 9; j++) begin
                step(1'b0, 1'b0, 1'b0);
                chk_state($sformatf("spaced_h%0d", k), pat(k), 1'b0);
            end
        end

        // signal_change held high: dwell 4/1/1/4/1/1 cycles
        step(1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 24; k++) begin
            step(1'b1, 1'b0, 1'b0);
            chk_state($sformatf("cont_t%0d", k), pat(k), 1'b0);
        end

        // Reset during EW_GREEN with a tick, a request and a pending request
        step(1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 7; k++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk_state("rst_mid_pre", EW_GREEN, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk_state("rst_mid", RED_B, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk_state("rst_mid_exit", NS_GREEN, 1'b0);

        // Request on the PED_WALK entry edge is kept for a second walk
        for (int k = 2; k <= 12; k++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk_state("walk2_req", RED_B, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk_state("walk2_enter", PED_WALK, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk_state("walk2_hold", PED_WALK, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk_state("walk2_exit", NS_GREEN, 1'b1);
        for (int k = 2; k <= 12; k++) step(1'b1, 1'b0, 1'b0);
        chk_state("walk2_redb", RED_B, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk_state("walk2_second", PED_WALK, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0);
        chk_state("walk2_done", NS_GREEN, 1'b0);

        // 100 idle cycles mid-NS_GREEN keep state and partial count
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 100; j++) begin
            step(1'b0, 1'b0, 1'b0);
            chk_state($sformatf("idle%0d", j), NS_GREEN, 1'b0);
        end
        step(1'b1, 1'b0, 1'b0);
        chk_state("idle_last", NS_GREEN, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk_state("idle_adv", NS_YELLOW, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/traffic_phase_fsm.md
TRAFFIC_PHASE_FSM -- requirements
Module: traffic_phase_fsm

Interface
REQ-001 Parameter GREEN_TICKS, default 4, number of signal_change ticks spent in each green phase (legal range 1..2**CNT_W).
REQ-002 Parameter YELLOW_TICKS, default 1, ticks per yellow phase (legal range 1..2**CNT_W).
REQ-003 Parameter ALLRED_TICKS, default 1, ticks per all-red clearance phase (legal range 1..2**CNT_W).
REQ-004 Parameter WALK_TICKS, default 3, ticks per pedestrian walk phase (legal range 1..2**CNT_W).
REQ-005 Parameter CNT_W, default 4, width of the tick counter.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 signal_change  input  1  phase-timer tick, nominally a one-cycle pulse; each high cycle counts as one tick.
REQ-009 ped_req  input  1  pedestrian request, pulse or level; each high cycle is sampled.
REQ-010 ns_light  output  3  north-south lamps {red,yellow,green}, exactly one bit set.
REQ-011 ew_light  output  3  east-west lamps {red,yellow,green}, exactly one bit set.
REQ-012 walk  output  1  pedestrian walk lamp.
REQ-013 ped_pending  output  1  latched pedestrian request awaiting service.
REQ-014 phase  output  3  current state encoding, for debug and bench checking.

Function
REQ-015 States SHALL be: NS_GREEN, NS_YELLOW, RED_A, EW_GREEN, EW_YELLOW, RED_B, PED_WALK.
REQ-016 A CNT_W-bit tick_cnt SHALL increment on each cycle with signal_change=1, and the state SHALL advance on the edge where signal_change=1 and tick_cnt equals the current phase duration minus 1.
REQ-017 tick_cnt SHALL return to 0 on every state transition; without ticks, state and tick_cnt SHALL hold indefinitely.
REQ-018 Transitions SHALL be: NS_GREEN->NS_YELLOW->RED_A->EW_GREEN->EW_YELLOW->RED_B.
REQ-019 On exit from RED_B: with ped_pending=1 the FSM SHALL go to PED_WALK; otherwise to NS_GREEN.
REQ-020 PED_WALK SHALL exit to NS_GREEN.
REQ-021 Phase durations SHALL be: NS_GREEN/EW_GREEN use GREEN_TICKS, yellows use YELLOW_TICKS, RED_A/RED_B use ALLRED_TICKS, PED_WALK uses WALK_TICKS.
REQ-022 A duration of 1 SHALL advance on every tick.
REQ-023 Lamp outputs SHALL be Moore-decoded from the registered state and change on the same edge as the state.
REQ-024 Lamp values per state:
- NS_GREEN: ns=001, ew=100.
- NS_YELLOW: ns=010, ew=100.
- EW_GREEN: ns=100, ew=001.
- EW_YELLOW: ns=100, ew=010.
- RED_A, RED_B, PED_WALK: ns=100, ew=100.
REQ-025 walk SHALL be 1 only in PED_WALK.
REQ-026 ped_pending SHALL set on any cycle with ped_req=1 and SHALL clear on the edge entering PED_WALK.
REQ-027 If ped_req=1 on the edge entering PED_WALK, set SHALL win: ped_pending remains 1 and is served on the next RED_B exit.
REQ-028 The FSM SHALL never produce green or yellow on both directions, and SHALL never assert walk while any lamp is non-red.

Reset
REQ-029 With rst=1 at a clock edge, the state SHALL go to RED_B, tick_cnt to 0, and ped_pending to 0, regardless of signal_change or ped_req that cycle.
REQ-030 Outputs after reset SHALL be: ns_light=100, ew_light=100, walk=0, ped_pending=0, phase=RED_B encoding.
REQ-031 Reset asserted mid-phase SHALL abandon that phase with no partial tick credit retained.

Structure
REQ-032 A shared package traffic_pkg SHALL hold the phase_e enum (3-bit), the lamp encoding constants (RED=3'b100, YELLOW=3'b010, GREEN=3'b001), and the default duration constants.
REQ-033 No sub-module SHALL be used: the tick counter and pedestrian latch stay inline, with a single next-state process and a single registered-state process.

Verification
REQ-034 Reset, then ticks every 10 cycles with defaults -> phase sequence NS_GREEN(4 ticks), NS_YELLOW(1), RED_A(1), EW_GREEN(4), EW_YELLOW(1), RED_B(1), repeating every 12 ticks; lamps match REQ-024.
REQ-035 One-cycle ped_req during EW_GREEN -> ped_pending=1; after the RED_B tick, PED_WALK with walk=1 and both lamps 100 for 3 ticks; then NS_GREEN with ped_pending=0.
REQ-036 signal_change held at 1 continuously -> state changes every 4/1/1/4/1/1 cycles; no illegal lamp combination on any cycle.
REQ-037 rst=1 for one cycle during EW_GREEN, with signal_change=1 and ped_pending=1 -> next cycle RED_B, tick_cnt=0, lamps 100/100, walk=0, ped_pending=0.
REQ-038 ped_req=1 on the cycle PED_WALK is entered -> ped_pending stays 1; a second PED_WALK follows the next RED_B.
REQ-039 No ticks for 100 cycles in NS_GREEN -> state, tick_cnt and lamps unchanged.
